// File: rtl/data_mem_responder_pkg.sv
// Shared types and encodings for the M-stage data memory.
//   mem_state_t : access FSM states (IDLE / BUSY / DONE)
//   F3_*        : funct3 load/store size and sign encodings
//   RESULT_MEM  : ResultSrc value that marks a load
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_MEM = 2'b01;

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load data extraction: picks the addressed byte/half lane out of a memory
// word and sign- or zero-extends it to 32 bits.
//   word_i   : full 32-bit memory word
//   off_i    : byte offset within the word (addr[1:0])
//   funct3_i : access size/sign
//   data_o   : extended load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    unique case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data memory with fixed multi-cycle access latency.
// Holds the pipeline via Stall_Mem while an access is in flight, then
// presents registered load data for one DONE cycle.
//   clk, reset    : clock, synchronous active-high reset
//   ResultSrc_M   : 2'b01 marks a load
//   MemWrite_M    : store request (wins over a simultaneous load)
//   funct3_M      : access size/sign
//   ALUResult_M   : byte address (wraps modulo DEPTH words)
//   WriteData_M   : right-aligned store data
//   ReadData_M    : registered, extended load result
//   Stall_Mem     : hold IF/ID/E/M while the access is pending
//   Misaligned_M  : combinational misaligned-request flag
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic        Stall_Mem,
  output logic        Misaligned_M
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          is_store, is_load, req;
  logic          is_byte, is_half, is_word;
  logic          misaligned, go, fire;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic [31:0]   load_val;
  logic          unused_addr_bits;

  assign idx = ALUResult_M[AW+1:2];
  assign off = ALUResult_M[1:0];
  assign unused_addr_bits = ^ALUResult_M[31:AW+2];

  always_comb begin
    is_store = MemWrite_M;
    is_load  = (ResultSrc_M == RESULT_MEM);
    req      = is_store | is_load;
    is_byte  = (funct3_M == F3_B) || (funct3_M == F3_BU);
    is_half  = (funct3_M == F3_H) || (funct3_M == F3_HU);
    is_word  = !is_byte && !is_half;
    misaligned = req && ((is_half && off[0]) || (is_word && (off != 2'b00)));
    go = req && !misaligned;
  end

  // Store lane replication plus byte-enable mask
  always_comb begin
    wmask = 4'b1111;
    wdata = WriteData_M;
    if (is_byte) begin
      wmask = 4'b0001 << off;
      wdata = {4{WriteData_M[7:0]}};
    end else if (is_half) begin
      wmask = off[1] ? 4'b1100 : 4'b0011;
      wdata = {2{WriteData_M[15:0]}};
    end
  end

  mem_load_align u_align (
    .word_i   (mem_q[idx]),
    .off_i    (off),
    .funct3_i (funct3_M),
    .data_o   (load_val)
  );

  // fire marks the access edge: straight from IDLE when LATENCY is 1,
  // otherwise when the BUSY countdown reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (LATENCY == 1) begin
            fire    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = 4'(LATENCY - 2);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (fire && !is_store) rdata_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately left out of reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && fire && is_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign ReadData_M   = rdata_q;
  assign Stall_Mem    = ((state_q == IDLE) && go) || (state_q == BUSY);
  assign Misaligned_M = misaligned;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rs = 2'b00;
  logic        mw = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        sel1 = 1'b0;

  logic [31:0] rd0, rd1;
  logic        st0, st1, mis0, mis1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // dut0: LATENCY=2; dut1: LATENCY=1; sel1 routes requests to one of them
  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .ResultSrc_M(sel1 ? 2'b00 : rs), .MemWrite_M(mw & ~sel1),
    .funct3_M(f3), .ALUResult_M(addr), .WriteData_M(wd),
    .ReadData_M(rd0), .Stall_Mem(st0), .Misaligned_M(mis0)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .ResultSrc_M(sel1 ? rs : 2'b00), .MemWrite_M(mw & sel1),
    .funct3_M(f3), .ALUResult_M(addr), .WriteData_M(wd),
    .ReadData_M(rd1), .Stall_Mem(st1), .Misaligned_M(mis1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Presents one request, counts stall cycles (bounded), returns ReadData in DONE.
  task automatic access(input logic m, input logic [1:0] r, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdv);
    @(posedge clk); #1;
    mw = m; rs = r; f3 = f; addr = a; wd = d;
    stalls = 0;
    @(negedge clk);
    while ((sel1 ? st1 : st0) && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    rdv = sel1 ? rd1 : rd0;
    @(posedge clk); #1;
    mw = 1'b0; rs = 2'b00; f3 = 3'b000; addr = '0; wd = '0;
  endtask

  task automatic store(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input int exp_st);
    int s; logic [31:0] r;
    access(1'b1, 2'b00, f, a, d, s, r);
    chk({tag, "_stall"}, 32'(s), 32'(exp_st));
  endtask

  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_st);
    int s; logic [31:0] r;
    access(1'b0, 2'b01, f, a, '0, s, r);
    chk({tag, "_stall"}, 32'(s), 32'(exp_st));
    chk(tag, r, exp);
  endtask

  // Presents a misaligned request for one cycle; expects no stall and no effect.
  task automatic misreq(input string tag, input logic m, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] rd_hold);
    @(posedge clk); #1;
    mw = m; rs = m ? 2'b00 : 2'b01; f3 = f; addr = a; wd = 32'h1111_1111;
    @(negedge clk);
    chk({tag, "_mis"}, 32'(mis0), 32'd1);
    chk({tag, "_stall"}, 32'(st0), 32'd0);
    @(posedge clk); #1;
    mw = 1'b0; rs = 2'b00; f3 = 3'b000; addr = '0; wd = '0;
    @(negedge clk);
    chk({tag, "_rd"}, rd0, rd_hold);
    chk({tag, "_stall_after"}, 32'(st0), 32'd0);
  endtask

  initial begin
    int s; logic [31:0] r;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rd", rd0, 32'h0);
    chk("rst_stall", 32'(st0), 32'd0);
    chk("rst_mis", 32'(mis0), 32'd0);
    chk("rst_rd1", rd1, 32'h0);

    // word store/load, 2 stall cycles each
    store("sw10", 3'b010, 32'h10, 32'hDEAD_BEEF, 2);
    load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF, 2);

    // byte store into zero word, signed/unsigned byte loads
    store("sw10z", 3'b010, 32'h10, 32'h0, 2);
    store("sb13", 3'b000, 32'h13, 32'h1234_5680, 2);
    load("lb13", 3'b000, 32'h13, 32'hFFFF_FF80, 2);
    load("lbu13", 3'b100, 32'h13, 32'h0000_0080, 2);
    load("lw10b", 3'b010, 32'h10, 32'h8000_0000, 2);

    // half store to upper lane, half/byte loads
    store("sh12", 3'b001, 32'h12, 32'hAAAA_BEEF, 2);
    load("lh12", 3'b001, 32'h12, 32'hFFFF_BEEF, 2);
    load("lhu12", 3'b101, 32'h12, 32'h0000_BEEF, 2);
    load("lb12", 3'b000, 32'h12, 32'hFFFF_FFEF, 2);
    load("lbu11", 3'b100, 32'h11, 32'h0, 2);
    load("lw10c", 3'b010, 32'h10, 32'hBEEF_0000, 2);

    // misaligned: no stall, no write, ReadData held
    misreq("lh11", 1'b0, 3'b001, 32'h11, 32'hBEEF_0000);
    misreq("lw12", 1'b0, 3'b010, 32'h12, 32'hBEEF_0000);
    misreq("sw12", 1'b1, 3'b010, 32'h12, 32'hBEEF_0000);
    misreq("sh13", 1'b1, 3'b001, 32'h13, 32'hBEEF_0000);
    load("lw10_after_mis", 3'b010, 32'h10, 32'hBEEF_0000, 2);

    // ResultSrc other than 01 is not a request
    access(1'b0, 2'b10, 3'b010, 32'h10, '0, s, r);
    chk("rs10_stall", 32'(s), 32'd0);
    chk("rs10_rd", r, 32'hBEEF_0000);

    // address wrap and unlisted funct3 treated as word
    store("sw0", 3'b010, 32'h0, 32'hCAFE_F00D, 2);
    load("lw400", 3'b010, 32'h400, 32'hCAFE_F00D, 2);
    load("f3_011", 3'b011, 32'h0, 32'hCAFE_F00D, 2);

    // reset while a store is in BUSY
    store("sw20z", 3'b010, 32'h20, 32'h0, 2);
    load("lw0_pre", 3'b010, 32'h0, 32'hCAFE_F00D, 2);
    @(posedge clk); #1;
    mw = 1'b1; f3 = 3'b010; addr = 32'h20; wd = 32'h5555_5555;
    @(negedge clk);
    chk("rb_stall_idle", 32'(st0), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rb_stall_busy", 32'(st0), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mw = 1'b0; f3 = 3'b000; addr = '0; wd = '0;
    @(negedge clk);
    chk("rb_stall_after", 32'(st0), 32'd0);
    chk("rb_rd_after", rd0, 32'h0);
    load("rb_lw20", 3'b010, 32'h20, 32'h0, 2);

    // LATENCY=1 instance, simultaneous store+load
    sel1 = 1'b1;
    store("l1_sw8", 3'b010, 32'h8, 32'h1234_5678, 1);
    load("l1_lw8", 3'b010, 32'h8, 32'h1234_5678, 1);
    access(1'b1, 2'b01, 3'b010, 32'h8, 32'h9ABC_DEF0, s, r);
    chk("l1_both_stall", 32'(s), 32'd1);
    chk("l1_both_rd", r, 32'h1234_5678);
    load("l1_lw8b", 3'b010, 32'h8, 32'h9ABC_DEF0, 1);
    sel1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
